// File: rtl/arrow_lane_if.sv
// arrow_lane_if: pixel, control and judgement signals of one lane.
// master drives frame_tick/spawn/hit_btn/x/y; slave returns pixels and judgements.
interface arrow_lane_if #(
  parameter int SLOTS = 4
);
  localparam int CW = $clog2(SLOTS + 1);

  logic          frame_tick;
  logic          spawn;
  logic          hit_btn;
  logic [9:0]    x;
  logic [9:0]    y;
  logic          arrow;
  logic          target;
  logic          flash;
  logic          hit;
  logic [CW-1:0] miss_n;
  logic          overflow;
  logic [CW-1:0] active_cnt;

  modport master (
    output frame_tick, spawn, hit_btn, x, y,
    input  arrow, target, flash, hit,
    input  miss_n, overflow, active_cnt
  );

  modport slave (
    input  frame_tick, spawn, hit_btn, x, y,
    output arrow, target, flash, hit,
    output miss_n, overflow, active_cnt
  );
endinterface

// File: rtl/arrow_lane.sv
// arrow_lane: one note lane - target arrow, scrolling notes, hit/miss judgement.
// Ports: clk, rst (sync, active-high), bus (arrow_lane_if.slave).
module arrow_lane #(
  parameter int LANE_X   = 50,
  parameter int TARGET_Y = 400,
  parameter int DIR      = 0,
  parameter int SLOTS    = 4,
  parameter int SPEED    = 2,
  parameter int HIT_WIN  = 12,
  parameter int HW       = 15,
  parameter int FLASH_FR = 4
) (
  input  logic        clk,
  input  logic        rst,
  arrow_lane_if.slave bus
);
  localparam int CW = $clog2(SLOTS + 1);
  localparam int IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int FW = $clog2(FLASH_FR + 1);
  localparam int SW = (2 * HW) / 5;

  localparam logic signed [11:0] P_HW = 12'(HW);
  localparam logic signed [11:0] P_SW = 12'(SW);
  localparam logic [10:0] LO  = 11'(TARGET_Y);
  localparam logic [10:0] LIM = 11'(TARGET_Y + HIT_WIN);
  localparam logic [10:0] WIN = 11'(HIT_WIN);
  localparam logic [10:0] SPD = 11'(SPEED);

  logic [SLOTS-1:0] r_valid;
  logic [9:0]       r_yc [SLOTS];
  logic             r_btn_prev;
  logic [FW-1:0]    r_flash_cnt;
  logic             r_hit;
  logic [CW-1:0]    r_miss_n;
  logic             r_overflow;
  logic [CW-1:0]    r_active_cnt;

  logic [SLOTS-1:0] w_valid_n;
  logic [9:0]       w_yc_n [SLOTS];
  logic [FW-1:0]    w_flash_n;
  logic             w_press;
  logic             w_win_ok;
  logic [IW-1:0]    w_win;
  logic [9:0]       w_best;
  logic             w_hit;
  logic             w_free_ok;
  logic [IW-1:0]    w_free;
  logic [CW-1:0]    w_miss;
  logic             w_ovf;
  logic [CW-1:0]    w_cnt;
  logic             w_arrow;
  logic             w_target;

  // Local frame is rotated so every orientation reuses the up-arrow test.
  function automatic logic f_shape(
    input logic [9:0] px, py, cx, cy
  );
    logic signed [11:0] dx, dy, u, v, au;
    logic head, stem;
    dx = $signed({2'b00, px}) - $signed({2'b00, cx});
    dy = $signed({2'b00, py}) - $signed({2'b00, cy});
    case (DIR)
      1: begin u = dx; v = -dy; end
      2: begin u = dy; v = dx;  end
      3: begin u = dy; v = -dx; end
      default: begin u = dx; v = dy; end
    endcase
    au   = (u < 0) ? -u : u;
    head = (v >= -P_HW) && (v < 0) && (au <= v + P_HW);
    stem = (v >= 0) && (v < P_HW) && (u >= -P_SW) && (u < P_SW);
    return head | stem;
  endfunction

  always_comb begin
    w_arrow = 1'b0;
    for (int i = 0; i < SLOTS; i++)
      if (r_valid[i] && f_shape(bus.x, bus.y, 10'(LANE_X), r_yc[i]))
        w_arrow = 1'b1;
    w_target = f_shape(bus.x, bus.y, 10'(LANE_X), 10'(TARGET_Y));
  end

  assign bus.arrow  = w_arrow;
  assign bus.target = w_target;
  assign bus.flash  = w_target & (r_flash_cnt != '0);

  always_comb begin
    w_press  = bus.hit_btn & ~r_btn_prev;
    w_win_ok = 1'b0;
    w_win    = '0;
    w_best   = '0;
    // Strict '>' keeps the lowest index on equal yc.
    for (int i = 0; i < SLOTS; i++)
      if (r_valid[i] &&
          ({1'b0, r_yc[i]} + WIN >= LO) &&
          ({1'b0, r_yc[i]} <= LIM))
        if (!w_win_ok || r_yc[i] > w_best) begin
          w_win_ok = 1'b1;
          w_win    = IW'(i);
          w_best   = r_yc[i];
        end
    w_hit = w_press & w_win_ok;

    // Free slot chosen from start-of-cycle state only.
    w_free_ok = 1'b0;
    w_free    = '0;
    for (int i = 0; i < SLOTS; i++)
      if (!r_valid[i] && !w_free_ok) begin
        w_free_ok = 1'b1;
        w_free    = IW'(i);
      end
    w_ovf = bus.spawn & ~w_free_ok;

    w_miss = '0;
    for (int i = 0; i < SLOTS; i++) begin
      w_valid_n[i] = r_valid[i];
      w_yc_n[i]    = r_yc[i];
      if (w_hit && w_win == IW'(i)) begin
        w_valid_n[i] = 1'b0;
      end else if (bus.frame_tick && r_valid[i]) begin
        w_yc_n[i] = r_yc[i] + 10'(SPEED);
        if ({1'b0, r_yc[i]} + SPD > LIM) begin
          w_valid_n[i] = 1'b0;
          w_miss       = w_miss + CW'(1);
        end
      end
      if (bus.spawn && w_free_ok && w_free == IW'(i)) begin
        w_valid_n[i] = 1'b1;
        w_yc_n[i]    = 10'(HW);
      end
    end

    if (w_hit)
      w_flash_n = FW'(FLASH_FR);
    else if (bus.frame_tick && r_flash_cnt != '0)
      w_flash_n = r_flash_cnt - FW'(1);
    else
      w_flash_n = r_flash_cnt;

    w_cnt = '0;
    for (int i = 0; i < SLOTS; i++)
      w_cnt = w_cnt + CW'(w_valid_n[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid      <= '0;
      for (int i = 0; i < SLOTS; i++)
        r_yc[i] <= '0;
      r_btn_prev   <= 1'b0;
      r_flash_cnt  <= '0;
      r_hit        <= 1'b0;
      r_miss_n     <= '0;
      r_overflow   <= 1'b0;
      r_active_cnt <= '0;
    end else begin
      r_valid      <= w_valid_n;
      for (int i = 0; i < SLOTS; i++)
        r_yc[i] <= w_yc_n[i];
      r_btn_prev   <= bus.hit_btn;
      r_flash_cnt  <= w_flash_n;
      r_hit        <= w_hit;
      r_miss_n     <= w_miss;
      r_overflow   <= w_ovf;
      r_active_cnt <= w_cnt;
    end
  end

  assign bus.hit        = r_hit;
  assign bus.miss_n     = r_miss_n;
  assign bus.overflow   = r_overflow;
  assign bus.active_cnt = r_active_cnt;
endmodule

// File: tb/tb_arrow_lane.sv
// tb_arrow_lane: directed and randomized checks of arrow_lane
// against a note-list reference model.
module tb_arrow_lane;
  localparam int SLOTS = 4;
  localparam int LX    = 50;
  localparam int TY    = 400;
  localparam int SPD   = 2;
  localparam int WIN   = 12;
  localparam int HWD   = 15;
  localparam int SWD   = (2 * HWD) / 5;
  localparam int FL    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  arrow_lane_if #(.SLOTS(SLOTS)) bus ();

  arrow_lane dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  bit mv [SLOTS];
  int my [SLOTS];
  bit mbtn;
  int mfl;
  int e_hit, e_miss, e_ovf, e_cnt;

  task automatic chk(string tag, int got, int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Up arrow: triangle rows above centre widen by one per row,
  // stem is a 2*SW-wide bar from centre down HW rows.
  function automatic bit ref_up(int px, int py, int cx, int cy);
    int dx, dy, half;
    dx = px - cx;
    dy = py - cy;
    if (dy >= -HWD && dy < 0) begin
      half = dy + HWD;
      return (dx >= -half) && (dx <= half);
    end
    if (dy >= 0 && dy < HWD)
      return (dx >= -SWD) && (dx < SWD);
    return 1'b0;
  endfunction

  task automatic model(bit r, bit f, bit s, bit b);
    bit pre [SLOTS];
    int best, d;
    if (r) begin
      for (int i = 0; i < SLOTS; i++) begin
        mv[i] = 0;
        my[i] = 0;
      end
      mbtn = 0; mfl = 0;
      e_hit = 0; e_miss = 0; e_ovf = 0; e_cnt = 0;
      return;
    end
    pre  = mv;
    best = -1;
    for (int i = 0; i < SLOTS; i++) begin
      d = my[i] - TY;
      if (d < 0) d = -d;
      if (mv[i] && d <= WIN)
        if (best < 0 || my[i] > my[best]) best = i;
    end
    e_hit = (b && !mbtn && best >= 0) ? 1 : 0;
    if (e_hit == 1) begin
      mv[best] = 0;
      mfl = FL;
    end else if (f && mfl > 0) begin
      mfl--;
    end
    e_miss = 0;
    if (f)
      for (int i = 0; i < SLOTS; i++)
        if (mv[i]) begin
          my[i] += SPD;
          if (my[i] > TY + WIN) begin
            mv[i] = 0;
            e_miss++;
          end
        end
    e_ovf = 0;
    if (s) begin
      best = -1;
      for (int i = SLOTS - 1; i >= 0; i--)
        if (!pre[i]) best = i;
      if (best < 0) e_ovf = 1;
      else begin
        mv[best] = 1;
        my[best] = HWD;
      end
    end
    mbtn  = b;
    e_cnt = 0;
    for (int i = 0; i < SLOTS; i++) e_cnt += mv[i];
  endtask

  task automatic step(bit r, bit f, bit s, bit b);
    rst            = r;
    bus.frame_tick = f;
    bus.spawn      = s;
    bus.hit_btn    = b;
    model(r, f, s, b);
    @(posedge clk);
    #1;
    bus.frame_tick = 1'b0;
    bus.spawn      = 1'b0;
    chk("hit", int'(bus.hit), e_hit);
    chk("miss_n", int'(bus.miss_n), e_miss);
    chk("overflow", int'(bus.overflow), e_ovf);
    chk("active_cnt", int'(bus.active_cnt), e_cnt);
  endtask

  task automatic probe(int px, int py);
    bit ea, et;
    bus.x = 10'(px);
    bus.y = 10'(py);
    #1;
    ea = 0;
    for (int i = 0; i < SLOTS; i++)
      if (mv[i] && ref_up(px, py, LX, my[i])) ea = 1;
    et = ref_up(px, py, LX, TY);
    chk("arrow_px", int'(bus.arrow), int'(ea));
    chk("target_px", int'(bus.target), int'(et));
    chk("flash_px", int'(bus.flash), int'(et && mfl != 0));
  endtask

  initial begin
    int px, py, k;
    bit r, f, s, b;
    bus.frame_tick = 1'b0;
    bus.spawn      = 1'b0;
    bus.hit_btn    = 1'b0;
    bus.x          = '0;
    bus.y          = '0;

    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("rst_active", int'(bus.active_cnt), 0);
    probe(50, 385);
    chk("apex_on", int'(bus.target), 1);
    probe(50, 384);
    chk("apex_off", int'(bus.target), 0);
    probe(50, 20);
    chk("rst_noarrow", int'(bus.arrow), 0);
    step(0, 0, 0, 0);

    step(0, 0, 1, 0);
    repeat (10) step(0, 1, 0, 0);
    chk("scroll_cnt", int'(bus.active_cnt), 1);
    probe(50, 35);
    chk("scroll_ctr", int'(bus.arrow), 1);
    probe(50, 20);
    chk("scroll_apex", int'(bus.arrow), 1);
    probe(50, 19);
    chk("scroll_above", int'(bus.arrow), 0);

    repeat (182) step(0, 1, 0, 0);
    step(0, 0, 0, 1);
    chk("press_hit", int'(bus.hit), 1);
    chk("press_cnt", int'(bus.active_cnt), 0);
    step(0, 0, 0, 1);
    chk("hold_nohit", int'(bus.hit), 0);
    for (int j = 0; j < 4; j++) begin
      probe(50, 400);
      chk("flash_on", int'(bus.flash), 1);
      step(0, 1, 0, 1);
      chk("hold_tick", int'(bus.hit), 0);
    end
    probe(50, 400);
    chk("flash_off", int'(bus.flash), 0);
    step(0, 0, 0, 0);

    step(0, 0, 1, 0);
    repeat (198) step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    chk("miss_one", int'(bus.miss_n), 1);
    chk("miss_cnt", int'(bus.active_cnt), 0);
    step(0, 0, 0, 0);
    chk("miss_pulse", int'(bus.miss_n), 0);

    for (int j = 0; j < 5; j++) begin
      step(0, 0, 1, 0);
      chk("ovf_seq", int'(bus.overflow), (j == 4) ? 1 : 0);
    end
    chk("ovf_cnt", int'(bus.active_cnt), 4);
    step(1, 1, 0, 0);
    chk("rst_nomiss", int'(bus.miss_n), 0);
    step(0, 0, 0, 0);
    probe(50, 20);

    step(0, 0, 1, 0);
    repeat (198) step(0, 1, 0, 0);
    step(0, 1, 0, 1);
    chk("late_hit", int'(bus.hit), 1);
    chk("late_nomiss", int'(bus.miss_n), 0);
    step(0, 0, 0, 0);

    step(0, 0, 1, 0);
    repeat (3) step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    repeat (192) step(0, 1, 0, 0);
    step(0, 0, 0, 1);
    chk("tie_hit", int'(bus.hit), 1);
    chk("tie_cnt", int'(bus.active_cnt), 1);
    probe(50, 418);
    chk("tie_lower_gone", int'(bus.arrow), 0);
    probe(50, 413);
    chk("tie_upper_kept", int'(bus.arrow), 1);
    step(1, 0, 0, 0);

    b = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      r = ($urandom_range(0, 299) == 0);
      f = ($urandom_range(0, 2) == 0);
      s = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) b = ~b;
      step(r, f, s, b);
      for (int j = 0; j < 2; j++) begin
        k  = $urandom_range(0, SLOTS - 1);
        px = LX - 20 + int'($urandom_range(0, 40));
        if (j == 0) py = my[k] - 20 + int'($urandom_range(0, 40));
        else        py = TY - 20 + int'($urandom_range(0, 40));
        if (py < 0) py = 0;
        if (py > 479) py = 479;
        probe(px, py);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
